traffic_light_fsm: RTL and testbench

//  Two-road intersection controller (north-south / east-west). Sits directly downstream of
//  the six-bit phase counter: samples its count Q as elapsed phase time, decides phase

---
 rtl/traffic_light_fsm_if.sv | 20 ++
 rtl/traffic_light_fsm.sv | 115 +++++++++++
 tb/tb_traffic_light_fsm.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_light_fsm_if.sv
// Signal bundle between the six-bit phase counter / car sensor side and the
// intersection controller.
interface traffic_light_fsm_if;
  logic [5:0] q;
  logic       ew_req;
  logic       cnt_clr;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       ew_wait;

  modport master (
    output q, ew_req,
    input  cnt_clr, ns_light, ew_light, ew_wait
  );

  modport slave (
    input  q, ew_req,
    output cnt_clr, ns_light, ew_light, ew_wait
  );
endinterface

// File: rtl/traffic_light_fsm.sv
// Two-road intersection controller: times each phase from the external phase
// counter, drives both light heads and restarts the counter on every phase entry.
module traffic_light_fsm #(
  parameter int unsigned G_MIN    = 20,
  parameter int unsigned G_MAX    = 50,
  parameter int unsigned EW_GREEN = 20,
  parameter int unsigned Y_TIME   = 5,
  parameter int unsigned R_TIME   = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  traffic_light_fsm_if.slave tl
);

  localparam logic [5:0] G_MIN_C    = 6'(G_MIN);
  localparam logic [5:0] G_MAX_C    = 6'(G_MAX);
  localparam logic [5:0] EW_GREEN_C = 6'(EW_GREEN);
  localparam logic [5:0] Y_TIME_C   = 6'(Y_TIME);
  localparam logic [5:0] R_TIME_C   = 6'(R_TIME);

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  typedef enum logic [2:0] {
    NS_G = 3'd0,
    NS_Y = 3'd1,
    RED1 = 3'd2,
    EW_G = 3'd3,
    EW_Y = 3'd4,
    RED2 = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic       cnt_clr_q, cnt_clr_d;
  logic [2:0] ns_light_q, ns_light_d;
  logic [2:0] ew_light_q, ew_light_d;
  logic       ew_wait_q, ew_wait_d;
  logic       phase_done;

  // Light pattern for a state, returned as {ns, ew}.
  function automatic logic [5:0] lights_of(input state_t s);
    logic [5:0] l;
    l = {LT_RED, LT_RED};
    case (s)
      NS_G:    l = {LT_GRN, LT_RED};
      NS_Y:    l = {LT_YEL, LT_RED};
      EW_G:    l = {LT_RED, LT_GRN};
      EW_Y:    l = {LT_RED, LT_YEL};
      default: l = {LT_RED, LT_RED};
    endcase
    return l;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_clr_d  = 1'b0;
    phase_done = 1'b0;
    ew_wait_d  = ew_wait_q;

    // q is stale while the clear is still applied to the counter.
    if (!cnt_clr_q) begin
      case (state_q)
        NS_G:       phase_done = ((tl.q >= G_MIN_C) && ew_wait_q) || (tl.q >= G_MAX_C);
        NS_Y, EW_Y: phase_done = (tl.q >= Y_TIME_C);
        RED1, RED2: phase_done = (tl.q >= R_TIME_C);
        EW_G:       phase_done = (tl.q >= EW_GREEN_C);
        default:    phase_done = 1'b0;
      endcase
    end

    case (state_q)
      NS_G: if (phase_done) state_d = NS_Y;
      NS_Y: if (phase_done) state_d = RED1;
      RED1: if (phase_done) state_d = EW_G;
      EW_G: if (phase_done) state_d = EW_Y;
      EW_Y: if (phase_done) state_d = RED2;
      RED2: if (phase_done) state_d = NS_G;
      default: state_d = RED2;
    endcase

    if (state_d != state_q) cnt_clr_d = 1'b1;

    // Clearing on EW green entry takes priority over a coincident request.
    if (state_d == EW_G && state_q != EW_G)
      ew_wait_d = 1'b0;
    else if (tl.ew_req && (state_q == NS_G || state_q == NS_Y ||
                           state_q == RED1 || state_q == RED2))
      ew_wait_d = 1'b1;

    {ns_light_d, ew_light_d} = lights_of(state_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RED2;
      cnt_clr_q  <= 1'b1;
      ns_light_q <= LT_RED;
      ew_light_q <= LT_RED;
      ew_wait_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_clr_q  <= cnt_clr_d;
      ns_light_q <= ns_light_d;
      ew_light_q <= ew_light_d;
      ew_wait_q  <= ew_wait_d;
    end
  end

  assign tl.cnt_clr  = cnt_clr_q;
  assign tl.ns_light = ns_light_q;
  assign tl.ew_light = ew_light_q;
  assign tl.ew_wait  = ew_wait_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Bench for traffic_light_fsm with the six-bit phase counter attached; expected
// phase entries are queued by the stimulus and checked by an independent monitor.
module tb_traffic_light_fsm;

  localparam int G_MIN = 20, G_MAX = 50, EW_GREEN = 20, Y_TIME = 5, R_TIME = 2;
  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;

  logic clk;
  logic reset_n;
  logic cnt_rst;

  traffic_light_fsm_if tif();

  traffic_light_fsm #(
    .G_MIN(G_MIN), .G_MAX(G_MAX), .EW_GREEN(EW_GREEN), .Y_TIME(Y_TIME), .R_TIME(R_TIME)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .tl      (tif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Six-bit phase counter, restarted by the controller's clear.
  assign cnt_rst = tif.cnt_clr | ~reset_n;
  always_ff @(posedge clk or posedge cnt_rst) begin
    if (cnt_rst) tif.q <= '0;
    else         tif.q <= tif.q + 6'd1;
  end

  typedef struct {
    logic [2:0] ns;
    logic [2:0] ew;
    logic       w;
    int         len;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string nm, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Expected phase length counts the cycles after the clear has dropped.
  task automatic push(input string nm, input logic [2:0] ns, input logic [2:0] ew,
                      input logic w, input int len);
    exp_t e;
    e.nm = nm; e.ns = ns; e.ew = ew; e.w = w; e.len = len;
    exp_q.push_back(e);
  endtask

  task automatic push_full_cycle(input string tag);
    push({tag, "_ns_g"}, G, R, 1'b0, G_MAX + 1);
    push({tag, "_ns_y"}, Y, R, 1'b0, Y_TIME + 1);
    push({tag, "_red1"}, R, R, 1'b0, R_TIME + 1);
    push({tag, "_ew_g"}, R, G, 1'b0, EW_GREEN + 1);
    push({tag, "_ew_y"}, R, Y, 1'b0, Y_TIME + 1);
    push({tag, "_red2"}, R, R, 1'b0, R_TIME + 1);
  endtask

  // Monitor: checks invariants every cycle and pops one expectation per phase entry.
  int         meas;
  int         cur_exp;
  string      cur_nm;
  logic       prev_clr;
  logic [2:0] prev_ns, prev_ew;

  always @(negedge clk) begin
    if (!reset_n) begin
      meas     = 0;
      cur_exp  = R_TIME + 1;
      cur_nm   = "red2_after_reset";
      prev_clr = 1'b1;
      prev_ns  = tif.ns_light;
      prev_ew  = tif.ew_light;
    end else begin
      logic entry, moved;
      exp_t e;
      entry = tif.cnt_clr && !prev_clr;
      moved = (tif.ns_light != prev_ns) || (tif.ew_light != prev_ew);
      check("ns_onehot", int'($onehot(tif.ns_light)), 1);
      check("ew_onehot", int'($onehot(tif.ew_light)), 1);
      check("both_not_red", int'((tif.ns_light != R) && (tif.ew_light != R)), 0);
      check("clr_width", int'(tif.cnt_clr && prev_clr), 0);
      check("clr_with_change", int'(moved), int'(entry));
      if (entry) begin
        check({cur_nm, "_len"}, meas, cur_exp);
        if (exp_q.size() == 0) begin
          check("unexpected_entry_ns", int'(tif.ns_light), -1);
          cur_exp = -1;
          cur_nm  = "unexpected";
        end else begin
          e = exp_q.pop_front();
          check({e.nm, "_ns"}, int'(tif.ns_light), int'(e.ns));
          check({e.nm, "_ew"}, int'(tif.ew_light), int'(e.ew));
          check({e.nm, "_wait"}, int'(tif.ew_wait), int'(e.w));
          cur_exp = e.len;
          cur_nm  = e.nm;
        end
        meas = 0;
      end else if (!tif.cnt_clr) begin
        meas++;
      end
      prev_clr = tif.cnt_clr;
      prev_ns  = tif.ns_light;
      prev_ew  = tif.ew_light;
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_ns"}, int'(tif.ns_light), int'(R));
    check({tag, "_ew"}, int'(tif.ew_light), int'(R));
    check({tag, "_clr"}, int'(tif.cnt_clr), 1);
    check({tag, "_wait"}, int'(tif.ew_wait), 0);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) return;
    end
    check({nm, "_drain_timeout"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Wait for a sample in a green phase (ns when ns_side=1) with the given count.
  task automatic wait_green(input logic ns_side, input logic [5:0] qv, input string nm);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (!tif.cnt_clr && tif.q == qv &&
          (ns_side ? (tif.ns_light == G) : (tif.ew_light == G))) return;
    end
    check({nm, "_wait_timeout"}, int'(tif.q), int'(qv));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    tif.ew_req = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset("reset");
    reset_n = 1'b1;

    // Free-running cycle, no demand.
    push_full_cycle("s1");
    drain("s1");

    // Demand before G_MIN: NS green ends at the minimum.
    push("s2_ns_g", G, R, 1'b0, G_MIN + 1);
    push("s2_ns_y", Y, R, 1'b1, Y_TIME + 1);
    push("s2_red1", R, R, 1'b1, R_TIME + 1);
    push("s2_ew_g", R, G, 1'b0, EW_GREEN + 1);
    push("s2_ew_y", R, Y, 1'b0, Y_TIME + 1);
    push("s2_red2", R, R, 1'b0, R_TIME + 1);
    wait_green(1'b1, 6'd5, "s2");
    tif.ew_req = 1'b1;
    @(negedge clk); #1;
    tif.ew_req = 1'b0;
    drain("s2");

    // Demand after G_MIN: exit on the edge after the request is latched.
    push("s3_ns_g", G, R, 1'b0, 32);
    push("s3_ns_y", Y, R, 1'b1, Y_TIME + 1);
    push("s3_red1", R, R, 1'b1, R_TIME + 1);
    push("s3_ew_g", R, G, 1'b0, EW_GREEN + 1);
    wait_green(1'b1, 6'd30, "s3");
    tif.ew_req = 1'b1;
    @(negedge clk); #1;
    tif.ew_req = 1'b0;
    drain("s3");

    // Request held through EW green/yellow is ignored.
    tif.ew_req = 1'b1;
    push("s4_ew_y", R, Y, 1'b0, Y_TIME + 1);
    push("s4_red2", R, R, 1'b0, R_TIME + 1);
    drain("s4a");
    tif.ew_req = 1'b0;
    // Pulse inside RED2 is latched and shortens the next NS green.
    push("s4_ns_g", G, R, 1'b1, G_MIN + 1);
    push("s4_ns_y", Y, R, 1'b1, Y_TIME + 1);
    push("s4_red1", R, R, 1'b1, R_TIME + 1);
    push("s4_ew_g", R, G, 1'b0, EW_GREEN + 1);
    @(negedge clk); #1;
    tif.ew_req = 1'b1;
    @(negedge clk); #1;
    tif.ew_req = 1'b0;
    drain("s4b");

    // Asynchronous reset in the middle of EW green.
    wait_green(1'b0, 6'd10, "s5");
    #1;
    reset_n = 1'b0;
    #1;
    check_reset("s5_async");
    check("s5_queue_empty", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    #1;
    check_reset("s5_held");
    reset_n = 1'b1;
    push_full_cycle("s5");
    push("s5_ns_g_again", G, R, 1'b0, G_MAX + 1);
    drain("s5");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
